// File: rtl/boron_if.sv
// Request/response bundle between a host and the BORON block-cipher core.
// The slave modport is the core's view; the master modport is the requester's view.
interface boron_if #(
   parameter int KEY_WIDTH = 80
);
   logic                 start_i;
   logic                 mode_i;
   logic [63:0]          text_in_i;
   logic [KEY_WIDTH-1:0] master_key_i;
   logic [63:0]          text_out_o;
   logic                 done_o;
   logic                 busy_o;

   modport master (
      output start_i, mode_i, text_in_i, master_key_i,
      input  text_out_o, done_o, busy_o
   );

   modport slave (
      input  start_i, mode_i, text_in_i, master_key_i,
      output text_out_o, done_o, busy_o
   );
endinterface

// File: rtl/boron_core.sv
// Iterative BORON encrypt/decrypt engine: one round and one key-schedule step per cycle.
// Decrypt first runs the key schedule forward to the last key, then walks it backward.
module boron_core #(
   parameter int KEY_WIDTH = 80,
   parameter int ROUNDS    = 25
) (
   input  logic    clk,
   input  logic    rst,
   boron_if.slave  bus
);

   localparam logic [4:0] LAST_UP = 5'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEYFWD,
      S_ROUND,
      S_FINAL,
      S_DONE
   } fsm_t;

   fsm_t                 fsm_q, fsm_d;
   logic [63:0]          state_q, state_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [4:0]           cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic [63:0]          text_out_q, text_out_d;

   logic [KEY_WIDTH-1:0] key_fwd, key_bwd;
   logic [4:0]           rc_up, rc_dn;
   logic [63:0]          rk_mix, enc_sub, enc_out, dec_pre, dec_out;
   logic                 round_last;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] r;
      r = 4'h0;
      case (x)
         4'h0: r = 4'hE;  4'h1: r = 4'h4;  4'h2: r = 4'hB;  4'h3: r = 4'h1;
         4'h4: r = 4'h7;  4'h5: r = 4'h9;  4'h6: r = 4'hC;  4'h7: r = 4'hA;
         4'h8: r = 4'hD;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'hF;
         4'hC: r = 4'h8;  4'hD: r = 4'h5;  4'hE: r = 4'h3;  4'hF: r = 4'h6;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] r;
      r = 4'h0;
      case (x)
         4'h0: r = 4'hA;  4'h1: r = 4'h3;  4'h2: r = 4'h9;  4'h3: r = 4'hE;
         4'h4: r = 4'h1;  4'h5: r = 4'hD;  4'h6: r = 4'hF;  4'h7: r = 4'h4;
         4'h8: r = 4'hC;  4'h9: r = 4'h5;  4'hA: r = 4'h7;  4'hB: r = 4'h2;
         4'hC: r = 4'h6;  4'hD: r = 4'h8;  4'hE: r = 4'h0;  4'hF: r = 4'hB;
      endcase
      return r;
   endfunction

   // Byte positions swap in pairs two apart, so the shuffle is its own inverse.
   function automatic logic [63:0] byte_shuffle(input logic [63:0] x);
      return {x[47:40], x[39:32], x[63:56], x[55:48],
              x[15:8],  x[7:0],   x[31:24], x[23:16]};
   endfunction

   function automatic logic [63:0] perm_fwd(input logic [63:0] x);
      logic [63:0] y;
      y = byte_shuffle(x);
      return {y[54:48], y[63:55],      // word 3 rotl 9
              y[40:32], y[47:41],      // word 2 rotl 7
              y[27:16], y[31:28],      // word 1 rotl 4
              y[14:0],  y[15]};        // word 0 rotl 1
   endfunction

   function automatic logic [63:0] perm_inv(input logic [63:0] x);
      return byte_shuffle({x[56:48], x[63:57],
                           x[38:32], x[47:39],
                           x[19:16], x[31:20],
                           x[0],     x[15:1]});
   endfunction

   function automatic logic [63:0] xor_fwd(input logic [63:0] x);
      logic [15:0] a, b, c, d;
      a = x[15:0] ^ x[31:16];
      c = x[47:32] ^ x[63:48];
      b = x[31:16] ^ c;
      d = x[63:48] ^ a;
      return {d, c, b, a};
   endfunction

   function automatic logic [63:0] xor_inv(input logic [63:0] y);
      logic [15:0] w0, w1, w2, w3;
      w1 = y[31:16] ^ y[47:32];
      w3 = y[63:48] ^ y[15:0];
      w0 = y[15:0] ^ w1;
      w2 = y[47:32] ^ w3;
      return {w3, w2, w1, w0};
   endfunction

   generate
      if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
         $error("boron_core: ROUNDS must lie in 1..31");
      end
   endgenerate

   // Round data path; decrypt mixes in the current key before undoing the layers.
   assign rk_mix = state_q ^ key_q[63:0];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
         assign enc_sub[4*gi +: 4] = sbox(rk_mix[4*gi +: 4]);
         assign dec_out[4*gi +: 4] = sbox_inv(dec_pre[4*gi +: 4]);
      end
   endgenerate

   assign enc_out = xor_fwd(perm_fwd(enc_sub));
   assign dec_pre = perm_inv(xor_inv(rk_mix));

   assign rc_up = cnt_q + 5'd1;
   assign rc_dn = cnt_q;

   generate
      if (KEY_WIDTH == 80) begin : g_ks80
         always_comb begin
            key_fwd         = {key_q[66:0], key_q[79:67]};
            key_fwd[3:0]    = sbox(key_fwd[3:0]);
            key_fwd[63:59]  = key_fwd[63:59] ^ rc_up;
            key_bwd         = key_q;
            key_bwd[63:59]  = key_bwd[63:59] ^ rc_dn;
            key_bwd[3:0]    = sbox_inv(key_bwd[3:0]);
            key_bwd         = {key_bwd[12:0], key_bwd[79:13]};
         end
      end else if (KEY_WIDTH == 128) begin : g_ks128
         always_comb begin
            key_fwd         = {key_q[114:0], key_q[127:115]};
            key_fwd[3:0]    = sbox(key_fwd[3:0]);
            key_fwd[7:4]    = sbox(key_fwd[7:4]);
            key_fwd[63:59]  = key_fwd[63:59] ^ rc_up;
            key_bwd         = key_q;
            key_bwd[63:59]  = key_bwd[63:59] ^ rc_dn;
            key_bwd[3:0]    = sbox_inv(key_bwd[3:0]);
            key_bwd[7:4]    = sbox_inv(key_bwd[7:4]);
            key_bwd         = {key_bwd[12:0], key_bwd[127:13]};
         end
      end else begin : g_bad_key
         $error("boron_core: KEY_WIDTH must be 80 or 128");
      end
   endgenerate

   // Encrypt counts up through the rounds; decrypt counts down to 1.
   assign round_last = mode_q ? (cnt_q == 5'd1) : (cnt_q == LAST_UP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= S_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         S_IDLE:   if (bus.start_i) fsm_d = bus.mode_i ? S_KEYFWD : S_ROUND;
         S_KEYFWD: if (cnt_q == LAST_UP) fsm_d = S_ROUND;
         S_ROUND:  if (round_last) fsm_d = S_FINAL;
         S_FINAL:  fsm_d = S_DONE;
         S_DONE:   fsm_d = S_IDLE;
         default:  fsm_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy_o     = (fsm_q != S_IDLE);
      bus.done_o     = (fsm_q == S_DONE);
      bus.text_out_o = text_out_q;
   end

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      text_out_d = text_out_q;
      case (fsm_q)
         S_IDLE: begin
            if (bus.start_i) begin
               state_d = bus.text_in_i;
               key_d   = bus.master_key_i;
               mode_d  = bus.mode_i;
               cnt_d   = 5'd0;
            end
         end
         S_KEYFWD: begin
            key_d = key_fwd;
            cnt_d = rc_up;
         end
         S_ROUND: begin
            if (mode_q) begin
               state_d = dec_out;
               key_d   = key_bwd;
               cnt_d   = cnt_q - 5'd1;
            end else begin
               state_d = enc_out;
               key_d   = key_fwd;
               cnt_d   = rc_up;
            end
         end
         // Key register now holds the last key (encrypt) or the master key (decrypt).
         S_FINAL:  text_out_d = rk_mix;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= '0;
         key_q      <= '0;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         text_out_q <= '0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         text_out_q <= text_out_d;
      end
   end

endmodule

// File: tb/tb_boron_core.sv
// Self-checking bench for boron_core: three builds (80/25, 128/25, 80/1 rounds)
// checked against a loop-based reference cipher.
module tb_boron_core;
   localparam int R = 25;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   boron_if #(.KEY_WIDTH(80))  if80 ();
   boron_if #(.KEY_WIDTH(128)) if128 ();
   boron_if #(.KEY_WIDTH(80))  if1 ();

   boron_core #(.KEY_WIDTH(80),  .ROUNDS(R)) dut80  (.clk(clk), .rst(rst), .bus(if80.slave));
   boron_core #(.KEY_WIDTH(128), .ROUNDS(R)) dut128 (.clk(clk), .rst(rst), .bus(if128.slave));
   boron_core #(.KEY_WIDTH(80),  .ROUNDS(1)) dut1   (.clk(clk), .rst(rst), .bus(if1.slave));

   int vectors = 0;
   int miscompares = 0;

   logic [3:0]  sb_tab [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
   logic [2:0]  done_w, busy_w;
   logic [63:0] tout_w [3];

   assign done_w    = {if1.done_o, if128.done_o, if80.done_o};
   assign busy_w    = {if1.busy_o, if128.busy_o, if80.busy_o};
   assign tout_w[0] = if80.text_out_o;
   assign tout_w[1] = if128.text_out_o;
   assign tout_w[2] = if1.text_out_o;

   function automatic logic [15:0] rotl16(logic [15:0] w, int n);
      logic [31:0] x;
      x = {w, w} << n;
      return x[31:16];
   endfunction

   function automatic logic [63:0] model_enc(logic [63:0] pt, logic [127:0] key, int kw, int rounds);
      logic [127:0] k, mask;
      logic [63:0]  s, t;
      logic [15:0]  w [4];
      logic [15:0]  a, b, c, d;
      int           rot [4];
      rot  = '{1, 4, 7, 9};
      mask = '1;
      if (kw == 80) mask = mask >> 48;
      k = key & mask;
      s = pt;
      for (int r = 1; r <= rounds; r++) begin
         s = s ^ k[63:0];
         for (int i = 0; i < 16; i++) s[4*i +: 4] = sb_tab[s[4*i +: 4]];
         for (int i = 0; i < 8; i++)  t[8*i +: 8] = s[8*(i ^ 2) +: 8];
         for (int j = 0; j < 4; j++)  w[j] = rotl16(t[16*j +: 16], rot[j]);
         a = w[0] ^ w[1];
         c = w[2] ^ w[3];
         b = w[1] ^ c;
         d = w[3] ^ a;
         s = {d, c, b, a};
         k = ((k << 13) | (k >> (kw - 13))) & mask;
         k[3:0] = sb_tab[k[3:0]];
         if (kw == 128) k[7:4] = sb_tab[k[7:4]];
         k[63:59] = k[63:59] ^ 5'(r);
      end
      return s ^ k[63:0];
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(int idx, logic st, logic md, logic [63:0] tx, logic [127:0] k);
      case (idx)
         0: begin
            if80.start_i = st; if80.mode_i = md; if80.text_in_i = tx; if80.master_key_i = k[79:0];
         end
         1: begin
            if128.start_i = st; if128.mode_i = md; if128.text_in_i = tx; if128.master_key_i = k;
         end
         default: begin
            if1.start_i = st; if1.mode_i = md; if1.text_in_i = tx; if1.master_key_i = k[79:0];
         end
      endcase
   endtask

   function automatic int dut_rounds(int idx);
      return (idx == 2) ? 1 : R;
   endfunction

   function automatic int dut_kw(int idx);
      return (idx == 1) ? 128 : 80;
   endfunction

   // One operation: start, optional hammering/scrambling while busy, then latency and result checks.
   task automatic run_op(string tag, int idx, logic md, logic [63:0] tx, logic [127:0] k,
                         logic [63:0] exp, bit hammer, bit scramble);
      int n;
      int lat;
      bit seen;
      n    = 0;
      seen = 1'b0;
      lat  = md ? 2 * dut_rounds(idx) + 2 : dut_rounds(idx) + 2;
      drive(idx, 1'b1, md, tx, k);
      while (!seen && n < 4 * R) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) check({tag, " busy"}, 64'(busy_w[idx]), 64'd1);
         if (done_w[idx]) seen = 1'b1;
         else if (scramble)
            drive(idx, hammer, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom});
         else
            drive(idx, hammer, md, tx, k);
      end
      $display("op %s dut=%0d mode=%0d in=%h cycles=%0d out=%h", tag, idx, md, tx, n, tout_w[idx]);
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " text_out"}, tout_w[idx], exp);
      @(posedge clk);
      #1;
      check({tag, " done one cycle"}, 64'(done_w[idx]), 64'd0);
      check({tag, " idle after done"}, 64'(busy_w[idx]), 64'd0);
      check({tag, " text_out held"}, tout_w[idx], exp);
      drive(idx, 1'b0, md, tx, k);
   endtask

   initial begin : main
      logic [63:0]  pt, ct, golden0;
      logic [127:0] key;
      int           idx, pulses;
      logic         md;
      bit           hm, sc;

      drive(0, 1'b1, 1'b0, 64'h0, 128'h0);
      drive(1, 1'b0, 1'b0, 64'h0, 128'h0);
      drive(2, 1'b0, 1'b0, 64'h0, 128'h0);
      golden0 = model_enc(64'h0, 128'h0, 80, R);

      // start held high throughout reset must not be taken
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset busy dut%0d", i), 64'(busy_w[i]), 64'd0);
         check($sformatf("reset done dut%0d", i), 64'(done_w[i]), 64'd0);
         check($sformatf("reset text_out dut%0d", i), tout_w[i], 64'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op("enc zero", 0, 1'b0, 64'h0, 128'h0, golden0, 1'b0, 1'b0);

      // Round trips on every build
      pt = 64'h0123456789ABCDEF;
      for (int i = 0; i < 3; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         ct  = model_enc(pt, key, dut_kw(i), dut_rounds(i));
         run_op($sformatf("rt enc dut%0d", i), i, 1'b0, pt, key, ct, 1'b0, 1'b0);
         run_op($sformatf("rt dec dut%0d", i), i, 1'b1, ct, key, pt, 1'b0, 1'b0);
      end

      // Hammered start, scrambled inputs, and both together
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom};
      run_op("hammer enc", 0, 1'b0, pt, key, model_enc(pt, key, 80, R), 1'b1, 1'b0);
      run_op("scramble enc", 1, 1'b0, pt, key, model_enc(pt, key, 128, R), 1'b0, 1'b1);
      run_op("hammer scramble dec", 1, 1'b1, model_enc(pt, key, 128, R), key, pt, 1'b1, 1'b1);

      // Random operations
      for (int i = 0; i < 10; i++) begin
         idx = $urandom_range(0, 2);
         md  = 1'($urandom_range(0, 1));
         hm  = 1'($urandom_range(0, 1));
         sc  = 1'($urandom_range(0, 1));
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom};
         ct  = model_enc(pt, key, dut_kw(idx), dut_rounds(idx));
         if (md) run_op($sformatf("rand dec %0d", i), idx, md, ct, key, pt, hm, sc);
         else    run_op($sformatf("rand enc %0d", i), idx, md, pt, key, ct, hm, sc);
      end

      // Reset in the middle of an encrypt aborts it without a done pulse
      drive(0, 1'b1, 1'b0, 64'h0, 128'h0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 64'h0, 128'h0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort busy immediate", 64'(busy_w[0]), 64'd0);
      check("abort text_out immediate", tout_w[0], 64'h0);
      @(posedge clk);
      #1;
      check("abort busy next cycle", 64'(busy_w[0]), 64'd0);
      check("abort text_out next cycle", tout_w[0], 64'h0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 2 * R; i++) begin
         @(posedge clk);
         #1;
         if (done_w[0]) pulses++;
      end
      $display("op abort dut=0 done_pulses=%0d", pulses);
      check("abort no done pulse", 64'(pulses), 64'd0);
      run_op("enc zero after abort", 0, 1'b0, 64'h0, 128'h0, golden0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
